// File: rtl/fetch_pc_if.sv
// fetch_pc_if: bundle between the branch-resolution side and the fetch PC
// controller.
//   master : drives Stall, PcSel, BrPC; observes PC, Flush, RedirPending,
//            TargetErr (and RedirCount).
//   slave  : the fetch_pc_ctrl side (inverse directions).
// Optional macro FETCH_REDIR_STATS_EN adds the 16-bit RedirCount signal.
interface fetch_pc_if #(
    parameter int PC_W = 9
);
    logic            Stall;
    logic            PcSel;
    logic [31:0]     BrPC;
    logic [PC_W-1:0] PC;
    logic            Flush;
    logic            RedirPending;
    logic            TargetErr;
`ifdef FETCH_REDIR_STATS_EN
    logic [15:0]     RedirCount;

    modport master (
        output Stall, PcSel, BrPC,
        input  PC, Flush, RedirPending, TargetErr, RedirCount
    );
    modport slave (
        input  Stall, PcSel, BrPC,
        output PC, Flush, RedirPending, TargetErr, RedirCount
    );
`else
    modport master (
        output Stall, PcSel, BrPC,
        input  PC, Flush, RedirPending, TargetErr
    );
    modport slave (
        input  Stall, PcSel, BrPC,
        output PC, Flush, RedirPending, TargetErr
    );
`endif
endinterface

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: owns the fetch program counter. Advances PC by 4 per cycle,
// redirects it to the branch/jump target on PcSel, parks a redirect that
// arrives during a stall and applies it on release, and generates the
// wrong-path Flush window for the front-end pipeline registers.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   bus (slave)  Stall, PcSel, BrPC in; PC, Flush, RedirPending, TargetErr out
// Parameters: PC_W (PC width), FLUSH_CYCLES (Flush window length, 1..7).
// Optional macro FETCH_REDIR_STATS_EN: adds a saturating 16-bit count of
// applied redirects on bus.RedirCount.
module fetch_pc_ctrl #(
    parameter int PC_W         = 9,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    fetch_pc_if.slave  bus
);
    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pend_r;
    logic            pend_err_r;
    logic            pending_r;
    logic [2:0]      flush_cnt_r;
    logic            flush_r;
    logic            target_err_r;

    logic [PC_W-1:0] target_s;
    logic            target_err_s;
    logic            apply_s;
    logic [PC_W-1:0] apply_pc_s;
    logic            apply_err_s;

    // Target formation and decision of whether a redirect lands this edge.
    always_comb begin
        target_s     = {bus.BrPC[PC_W-1:2], 2'b00};
        target_err_s = (bus.BrPC[1:0] != 2'b00) || (|bus.BrPC[31:PC_W]);
        apply_s      = 1'b0;
        apply_pc_s   = target_s;
        apply_err_s  = target_err_s;
        case (state_r)
            RUN: begin
                if (bus.PcSel && !bus.Stall) begin
                    apply_s = 1'b1;
                end else begin
                    apply_s = 1'b0;
                end
            end
            HOLD: begin
                if (!bus.Stall) begin
                    apply_s = 1'b1;
                    // A fresh redirect on the release edge supersedes pend.
                    if (!bus.PcSel) begin
                        apply_pc_s  = pend_r;
                        apply_err_s = pend_err_r;
                    end else begin
                        apply_pc_s  = target_s;
                        apply_err_s = target_err_s;
                    end
                end else begin
                    apply_s = 1'b0;
                end
            end
            default: begin
                apply_s = 1'b0;
            end
        endcase
    end

    // RUN/HOLD state machine, PC register and pending-redirect storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= RUN;
            pc_r         <= '0;
            pend_r       <= '0;
            pend_err_r   <= 1'b0;
            pending_r    <= 1'b0;
            target_err_r <= 1'b0;
        end else begin
            target_err_r <= apply_s && apply_err_s;
            case (state_r)
                RUN: begin
                    if (bus.PcSel && bus.Stall) begin
                        pend_r     <= target_s;
                        pend_err_r <= target_err_s;
                        pending_r  <= 1'b1;
                        state_r    <= HOLD;
                    end else if (apply_s) begin
                        pc_r <= apply_pc_s;
                    end else if (!bus.Stall) begin
                        pc_r <= pc_r + PC_W'(4);
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                HOLD: begin
                    if (bus.Stall) begin
                        // Newest redirect wins while still frozen.
                        if (bus.PcSel) begin
                            pend_r     <= target_s;
                            pend_err_r <= target_err_s;
                        end else begin
                            pend_r     <= pend_r;
                        end
                    end else begin
                        pc_r      <= apply_pc_s;
                        pending_r <= 1'b0;
                        state_r   <= RUN;
                    end
                end
                default: begin
                    state_r   <= RUN;
                    pending_r <= 1'b0;
                end
            endcase
        end
    end

    // Flush window counter; runs down independently of Stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_cnt_r <= 3'd0;
            flush_r     <= 1'b0;
        end else if (apply_s) begin
            flush_cnt_r <= FLUSH_INIT;
            flush_r     <= (FLUSH_INIT != 3'd0);
        end else if (flush_cnt_r != 3'd0) begin
            flush_cnt_r <= flush_cnt_r - 3'd1;
            flush_r     <= (flush_cnt_r > 3'd1);
        end else begin
            flush_cnt_r <= 3'd0;
            flush_r     <= 1'b0;
        end
    end

`ifdef FETCH_REDIR_STATS_EN
    logic [15:0] redir_count_r;

    // Saturating count of redirects that actually reached the PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_count_r <= 16'd0;
        end else if (apply_s && (redir_count_r != 16'hFFFF)) begin
            redir_count_r <= redir_count_r + 16'd1;
        end else begin
            redir_count_r <= redir_count_r;
        end
    end

    assign bus.RedirCount = redir_count_r;
`endif

    assign bus.PC           = pc_r;
    assign bus.Flush        = flush_r;
    assign bus.RedirPending = pending_r;
    assign bus.TargetErr    = target_err_r;
endmodule
